// File: rtl/chan_stream_pkg.sv
// Shared sample-stream definitions for the filter output path and its sinks.
package chan_stream_pkg;

  localparam int DATA_W           = 16;
  localparam int DEF_CHANNELS     = 5;
  localparam int DEF_CHANNELS_PW2 = 7;
  localparam int FRAME_COUNT_W    = 16;

  typedef logic [DATA_W-1:0] sample_t;

endpackage

// File: rtl/frame_bank_ram.sv
// Two banks of CHANNELS sample registers: one write port, one registered read port.
// Reads of a channel index beyond CHANNELS return zero.
module frame_bank_ram #(
  parameter int CHANNELS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2][CHANNELS];
  logic [DATA_W-1:0] rd_next;

  // Bank contents carry no reset; only published frames are ever read meaningfully.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_addr == ADDR_W'(c)) mem[wr_bank][c] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_next = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd_addr == ADDR_W'(c)) rd_next = mem[rd_bank][c];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= rd_next;
  end

endmodule

// File: rtl/chan_frame_collector.sv
// Collects in-order per-channel samples into double-buffered frames; 1-cycle read latency.
// Only the last channel of a frame stalls, until the previously published frame is acked.
module chan_frame_collector #(
  parameter int CHANNELS     = chan_stream_pkg::DEF_CHANNELS,
  parameter int CHANNELS_PW2 = chan_stream_pkg::DEF_CHANNELS_PW2,
  parameter int DATA_W       = chan_stream_pkg::DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       chan_in_sample,
  input  logic [CHANNELS_PW2-1:0] chan_in_num,
  input  logic                    chan_in_valid,
  output logic                    chan_in_read,
  output logic                    frame_valid,
  input  logic                    frame_ack,
  input  logic [CHANNELS_PW2-1:0] rd_addr,
  output logic [DATA_W-1:0]       rd_data,
  output logic [15:0]             frame_count,
  output logic                    err_seq,
  input  logic                    err_clr
);

  import chan_stream_pkg::*;

  localparam logic [CHANNELS_PW2-1:0] LAST_CH = CHANNELS_PW2'(CHANNELS - 1);
  localparam logic [CHANNELS_PW2:0]   NUM_CH  = (CHANNELS_PW2 + 1)'(CHANNELS);

  logic [CHANNELS_PW2-1:0] exp_ch;
  logic                    bank_sel;
  logic                    xfer;
  logic                    in_order;
  logic                    seq_err;
  logic                    frame_done;
  logic                    wr_en;

  assign chan_in_read = !reset && !(frame_valid && exp_ch == LAST_CH);
  assign xfer         = chan_in_valid && chan_in_read;
  assign in_order     = (chan_in_num == exp_ch) && ({1'b0, chan_in_num} < NUM_CH);
  assign seq_err      = xfer && !in_order;
  assign frame_done   = xfer && in_order && (exp_ch == LAST_CH);
  // A stray channel 0 restarts the frame rather than being thrown away.
  assign wr_en        = xfer && (in_order || chan_in_num == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_ch      <= '0;
      bank_sel    <= 1'b0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      err_seq     <= 1'b0;
    end else begin
      if (seq_err)         exp_ch <= (chan_in_num == '0) ? CHANNELS_PW2'(1) : '0;
      else if (frame_done) exp_ch <= '0;
      else if (xfer)       exp_ch <= exp_ch + 1'b1;

      if (frame_done) begin
        bank_sel    <= ~bank_sel;
        frame_count <= frame_count + FRAME_COUNT_W'(1);
      end

      if (frame_done)     frame_valid <= 1'b1;
      else if (frame_ack) frame_valid <= 1'b0;

      if (seq_err)      err_seq <= 1'b1;
      else if (err_clr) err_seq <= 1'b0;
    end
  end

  frame_bank_ram #(
    .CHANNELS (CHANNELS),
    .ADDR_W   (CHANNELS_PW2),
    .DATA_W   (DATA_W)
  ) u_banks (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_bank (bank_sel),
    .wr_addr (chan_in_num),
    .wr_data (chan_in_sample),
    .rd_bank (~bank_sel),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_chan_frame_collector.sv
// Directed scenarios plus randomized traffic against a frame-level reference model.
module tb_chan_frame_collector;
  import chan_stream_pkg::*;

  localparam int CH = DEF_CHANNELS;
  localparam int PW = DEF_CHANNELS_PW2;
  localparam int W  = DATA_W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  chan_in_sample = '0;
  logic [PW-1:0] chan_in_num = '0;
  logic          chan_in_valid = 1'b0;
  logic          chan_in_read;
  logic          frame_valid;
  logic          frame_ack = 1'b0;
  logic [PW-1:0] rd_addr = '0;
  logic [W-1:0]  rd_data;
  logic [15:0]   frame_count;
  logic          err_seq;
  logic          err_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  // Reference model: frame being filled, last published frame, flags.
  int           m_exp;
  logic [W-1:0] m_fill [CH];
  logic [W-1:0] m_pub  [CH];
  bit           m_pub_known;
  bit           m_fv;
  bit           m_err;
  int           m_fc;
  logic [W-1:0] m_rd;
  bit           m_rd_known;

  chan_frame_collector dut (
    .clk            (clk),
    .reset          (reset),
    .chan_in_sample (chan_in_sample),
    .chan_in_num    (chan_in_num),
    .chan_in_valid  (chan_in_valid),
    .chan_in_read   (chan_in_read),
    .frame_valid    (frame_valid),
    .frame_ack      (frame_ack),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .frame_count    (frame_count),
    .err_seq        (err_seq),
    .err_clr        (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_read();
    return !(m_fv && m_exp == CH - 1);
  endfunction

  // Called at a falling edge: drive inputs, predict the next edge, check after it.
  task automatic cycle(input bit v, input int num, input int smp, input bit ack,
                       input int addr, input bit clr);
    bit xfer;
    bit err_new;
    chan_in_valid  = v;
    chan_in_num    = num[PW-1:0];
    chan_in_sample = smp[W-1:0];
    frame_ack      = ack;
    rd_addr        = addr[PW-1:0];
    err_clr        = clr;
    #1;
    check("chan_in_read", chan_in_read, m_read());

    m_rd_known = (addr >= CH) || m_pub_known;
    m_rd       = (addr >= CH) ? '0 : m_pub[addr];

    xfer    = v && m_read();
    err_new = 1'b0;
    if (ack) m_fv = 1'b0;
    if (xfer) begin
      if (num == m_exp && num < CH) begin
        m_fill[num] = smp[W-1:0];
        if (m_exp == CH - 1) begin
          m_pub       = m_fill;
          m_pub_known = 1'b1;
          m_fv        = 1'b1;
          m_fc        = (m_fc + 1) % 65536;
          m_exp       = 0;
        end else begin
          m_exp++;
        end
      end else begin
        err_new = 1'b1;
        if (num == 0) begin
          m_fill[0] = smp[W-1:0];
          m_exp     = 1;
        end else begin
          m_exp = 0;
        end
      end
    end
    if (err_new)  m_err = 1'b1;
    else if (clr) m_err = 1'b0;

    @(posedge clk);
    @(negedge clk);
    check("frame_valid", frame_valid, m_fv);
    check("frame_count", frame_count, m_fc);
    check("err_seq", err_seq, m_err);
    if (m_rd_known) check("rd_data", rd_data, m_rd);
  endtask

  task automatic idle(input int addr);
    cycle(1'b0, 0, 0, 1'b0, addr, 1'b0);
  endtask

  task automatic do_reset(input int cyc);
    reset         = 1'b1;
    chan_in_valid = 1'b0;
    frame_ack     = 1'b0;
    err_clr       = 1'b0;
    #1;
    check("rst_read", chan_in_read, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_err_seq", err_seq, 0);
    check("rst_rd_data", rd_data, 0);
    repeat (cyc) @(negedge clk);
    check("rst_hold_read", chan_in_read, 0);
    check("rst_hold_rd_data", rd_data, 0);
    reset       = 1'b0;
    m_exp       = 0;
    m_fv        = 1'b0;
    m_err       = 1'b0;
    m_fc        = 0;
    m_pub_known = 1'b0;
    #1;
    check("post_rst_read", chan_in_read, 1);
  endtask

  initial begin
    int num;
    @(negedge clk);
    do_reset(2);
    idle(0);
    check("post_rst_count", frame_count, 0);

    // Single frame, back to back, then readout sweep.
    for (int i = 0; i < CH; i++) cycle(1'b1, i, i + 1, 1'b0, 0, 1'b0);
    check("frame1_valid", frame_valid, 1);
    check("frame1_count", frame_count, 1);
    for (int a = 0; a < CH; a++) begin
      idle(a);
      check("frame1_rd", rd_data, a + 1);
    end
    idle(6);
    check("rd_out_of_range", rd_data, 0);

    // Backpressure on the last channel while frame 1 is unacked.
    for (int i = 0; i < CH - 1; i++) cycle(1'b1, i, 'h11 + i, 1'b0, 0, 1'b0);
    repeat (3) cycle(1'b1, 4, 'h15, 1'b0, 0, 1'b0);
    #1;
    check("bp_read_held", chan_in_read, 0);
    cycle(1'b1, 4, 'h15, 1'b1, 0, 1'b0);
    check("bp_ack_clears", frame_valid, 0);
    cycle(1'b1, 4, 'h15, 1'b0, 4, 1'b0);
    check("bp_republished", frame_valid, 1);
    idle(4);
    check("bp_rd_ch4", rd_data, 'h15);
    check("bp_count", frame_count, 2);

    // Sequence error 0,1,3, then a clean frame, then clear.
    cycle(1'b0, 0, 0, 1'b1, 0, 1'b0);
    cycle(1'b1, 0, 'h20, 1'b0, 0, 1'b0);
    cycle(1'b1, 1, 'h21, 1'b0, 0, 1'b0);
    cycle(1'b1, 3, 'h23, 1'b0, 0, 1'b0);
    check("seq_err_set", err_seq, 1);
    check("seq_no_frame", frame_valid, 0);
    for (int i = 0; i < CH; i++) cycle(1'b1, i, 'h31 + i, 1'b0, 0, 1'b0);
    check("seq_recovered_count", frame_count, 3);
    idle(2);
    check("seq_recovered_rd", rd_data, 'h33);
    cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
    check("seq_err_clr", err_seq, 0);

    // Out-of-range channel, then error coinciding with clear.
    cycle(1'b0, 0, 0, 1'b1, 0, 1'b0);
    cycle(1'b1, 5, 'h55, 1'b0, 0, 1'b0);
    check("oor_err", err_seq, 1);
    cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
    cycle(1'b1, 7, 'h77, 1'b0, 0, 1'b1);
    check("err_beats_clr", err_seq, 1);
    for (int i = 0; i < CH; i++) cycle(1'b1, i, 'h41 + i, 1'b0, 0, 1'b0);
    check("oor_exp_restart", frame_count, 4);

    // Reset mid-frame, then a frame delivered with gaps.
    cycle(1'b0, 0, 0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, i, 'h60 + i, 1'b0, 0, 1'b0);
    do_reset(2);
    idle(0);
    check("midrst_no_frame", frame_valid, 0);
    for (int i = 0; i < CH; i++) begin
      cycle(1'b1, i, 'h71 + i, 1'b0, 0, 1'b0);
      idle(0);
      idle(0);
    end
    check("gap_count", frame_count, 1);
    idle(0);
    check("gap_rd", rd_data, 'h71);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0:       num = $urandom_range(0, 7);
        1:       num = $urandom_range(0, (1 << PW) - 1);
        default: num = m_exp;
      endcase
      cycle($urandom_range(0, 3) != 0, num, $urandom_range(0, 65535),
            $urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chan_frame_collector.md
# chan_frame_collector

Stream sink for the per-channel sample stream produced by `CUST_HP_filter`: it is the reader at the far end of the `chan_*_sample/num/valid/read` handshake. Accepts samples one channel at a time, checks that channels arrive in order `0 … CHANNELS-1`, and assembles each complete frame into a double-buffered register bank. The downstream logic (stimulation decision / USB readout) holds a published frame, reads it at random address, then releases it with an acknowledge.

## Interface

Parameters:
- `CHANNELS`, 5, channels per frame.
- `CHANNELS_PW2`, 7, width of channel-number fields; requires 2^`CHANNELS_PW2` ≥ `CHANNELS`.
- `DATA_W`, 16, sample width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `chan_in_sample` in `DATA_W`: sample from the filter output.
- `chan_in_num` in `CHANNELS_PW2`: binary channel index of the sample.
- `chan_in_valid` in 1: the sample and index are valid.
- `chan_in_read` out 1: this block accepts the sample. A transfer occurs on a rising edge where `chan_in_valid && chan_in_read`.
- `frame_valid` out 1: the read bank holds a complete, unacknowledged frame.
- `frame_ack` in 1: single-cycle release of the read bank. Ignored while `frame_valid=0`.
- `rd_addr` in `CHANNELS_PW2`: channel index to read from the read bank.
- `rd_data` out `DATA_W`: registered read data.
- `frame_count` out 16: number of frames published; wraps from 0xFFFF to 0.
- `err_seq` out 1: sticky sequence-error flag.
- `err_clr` in 1: clears `err_seq`.

## Operation

Internal state:
- `exp_ch`: expected channel index.
- `bank_sel`: selects the fill bank.
- Two banks of `CHANNELS` × `DATA_W` registers.

On each transfer:
- If `num == exp_ch` and `num < CHANNELS`:
  - Write the sample to `fill[num]`.
  - If `exp_ch == CHANNELS-1`, the frame is complete. Toggle `bank_sel`, set `frame_valid`, increment `frame_count`, and set `exp_ch` to 0.
  - Otherwise increment `exp_ch`.
- If `num != exp_ch` or `num ≥ CHANNELS`: this is a sequence error.
  - Set `err_seq` and discard the partial frame.
  - If `num == 0`, write the sample to `fill[0]` and set `exp_ch` to 1.
  - Otherwise drop the sample and set `exp_ch` to 0.

Backpressure and readout:
- `chan_in_read = !(frame_valid && exp_ch == CHANNELS-1)`. This is a function of registers only; there is no combinational path from `chan_in_valid` or `frame_ack`. The final sample of a frame therefore waits until the previous frame is acknowledged, and earlier channels are always accepted.
- `frame_ack` while `frame_valid=1` clears `frame_valid` on the next edge.
- Frame completion cannot coincide with a valid ack, because completion requires `frame_valid=0`.
- `rd_data <= read_bank[rd_addr]`. If `rd_addr ≥ CHANNELS`, `rd_data <= 0`.

Error flag:
- `err_clr` clears `err_seq`.
- If a new error and `err_clr` occur in the same cycle, the error wins and `err_seq=1`.

## Timing

Reset values:
- `chan_in_read=0` while `reset` is asserted, and 1 in the first cycle after release.
- `frame_valid=0`, `rd_data=0`, `frame_count=0`, `err_seq=0`.
- `exp_ch=0`, `bank_sel=0`. Bank contents are don't-care.
- Reset asserted mid-frame discards the partial frame and any published frame.

Latencies:
- Last-channel transfer at edge N: `frame_valid=1`, new `frame_count`, and bank swap are visible after edge N.
- `rd_addr` presented before edge N: `rd_data` is valid after edge N (1-cycle latency).
- `frame_ack` sampled at edge N: `frame_valid=0` and `chan_in_read=1` after edge N.
- Back-to-back transfers at one per cycle are sustained except at the blocked last channel.
- Gaps in `chan_in_valid` have no effect on state.

## Structure

- Package `chan_stream_pkg`:
  - `DATA_W`, default `CHANNELS`, default `CHANNELS_PW2`.
  - `sample_t` typedef.
  - Shared with `CUST_HP_filter` and the test benches.
- Sub-module `frame_bank_ram`: dual-bank register file with one write port (addressed by bank and channel) and one registered read port. The top level holds `exp_ch`, the handshake, the error logic and the counters.

## Test plan

1. Reset: hold `reset` for 2 cycles → all outputs 0. After release, `chan_in_read=1` and `frame_count=0`.
2. Single frame: channels 0..4 with samples 0x0001..0x0005, back-to-back → `frame_valid=1` after the 5th edge and `frame_count=1`. Sweeping `rd_addr` 0..4 returns 0x0001..0x0005 one cycle later; `rd_addr=6` returns 0.
3. Backpressure: leave frame 1 unacked and send channels 0..4 with samples 0x0011..0x0015 → channels 0..3 accepted, `chan_in_read=0` while channel 4 is held. After `frame_ack`, channel 4 is accepted on the next edge, `frame_valid` reasserts, and `rd_addr=4` returns 0x0015.
4. Sequence error: send channels 0, 1, 3 → `err_seq=1`, no frame published. Then send channels 0..4 → the frame is published intact. Pulse `err_clr` → `err_seq=0`.
5. Out-of-range index: `chan_in_num=5` → `err_seq=1`, sample dropped, `exp_ch=0`. Error and `err_clr` in the same cycle → `err_seq` stays 1.
6. Reset mid-frame: send channels 0..2, assert `reset` → no frame published. After release, channels 0..4 with gaps in `chan_in_valid` → one frame published, `frame_count=1`.
